// File: rtl/template_db_reg_bank.sv
// Double-buffered template register bank: shadows load by serial chain or addressed write; TRANSFER commits them to Q one cycle later.
// No backpressure: SHIFT_EN > LOAD_EN > TRANSFER; the lower-priority request in a colliding cycle is dropped and sets ERR.
module template_db_reg_bank #(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 4,
  parameter int AUTO_XFER = 0,
  localparam int AW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      SHIFT_EN,
  input  logic                      SDI,
  output logic                      SDO,
  input  logic                      LOAD_EN,
  input  logic [AW-1:0]             LOAD_ADDR,
  input  logic [WIDTH-1:0]          LOAD_DATA,
  input  logic                      TRANSFER,
  input  logic [CHANNELS-1:0]       CH_MASK,
  input  logic                      ERR_CLR,
  output logic [CHANNELS*WIDTH-1:0] Q,
  output logic [CHANNELS-1:0]       PENDING,
  output logic                      FRAME_DONE,
  output logic                      ERR
);

  localparam int N  = CHANNELS * WIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // chain holds all shadows back to back; shadow c lives at chain[c*WIDTH +: WIDTH]
  logic [N-1:0]          chain, chain_nxt;
  logic [N-1:0]          q_r, q_nxt;
  logic [CHANNELS-1:0]   pend, pend_nxt;
  logic [CHANNELS-1:0]   commit_mask;
  logic [CW-1:0]         cnt;
  logic                  frame_done_r, auto_pend, err_r;
  logic                  addr_ok, frame_end, mid_frame;
  logic                  do_xfer, auto_now, auto_ok, err_set;

  assign addr_ok   = int'(LOAD_ADDR) < CHANNELS;
  assign frame_end = SHIFT_EN && (cnt == LAST);
  assign mid_frame = (cnt != '0);
  assign do_xfer   = TRANSFER && !SHIFT_EN && !LOAD_EN;
  assign auto_now  = (AUTO_XFER != 0) && auto_pend;
  assign auto_ok   = auto_now && !SHIFT_EN && !LOAD_EN;

  assign commit_mask = ((do_xfer && !mid_frame) ? CH_MASK : '0) |
                       (auto_ok ? {CHANNELS{1'b1}} : '0);

  assign err_set = (SHIFT_EN && (LOAD_EN || TRANSFER)) ||
                   (LOAD_EN && TRANSFER) ||
                   (LOAD_EN && !SHIFT_EN && !addr_ok) ||
                   (do_xfer && mid_frame) ||
                   (auto_now && (SHIFT_EN || LOAD_EN));

  always_comb begin
    chain_nxt = chain;
    pend_nxt  = pend;
    q_nxt     = q_r;
    if (SHIFT_EN) begin
      chain_nxt      = chain >> 1;
      chain_nxt[N-1] = SDI;
      if (frame_end) pend_nxt = '1;
    end else if (LOAD_EN && addr_ok) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (int'(LOAD_ADDR) == c) begin
          chain_nxt[c*WIDTH +: WIDTH] = LOAD_DATA;
          pend_nxt[c]                 = 1'b1;
        end
      end
    end
    // commits only happen in cycles without shift/load, so chain is stable here
    for (int c = 0; c < CHANNELS; c++) begin
      if (commit_mask[c]) begin
        q_nxt[c*WIDTH +: WIDTH] = chain[c*WIDTH +: WIDTH];
        pend_nxt[c]             = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      chain        <= '0;
      q_r          <= '0;
      pend         <= '0;
      cnt          <= '0;
      frame_done_r <= 1'b0;
      auto_pend    <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      chain        <= chain_nxt;
      q_r          <= q_nxt;
      pend         <= pend_nxt;
      if (SHIFT_EN) cnt <= frame_end ? '0 : cnt + 1'b1;
      frame_done_r <= frame_end;
      auto_pend    <= (AUTO_XFER != 0) && frame_done_r;
      err_r        <= err_set || (err_r && !ERR_CLR);
    end
  end

  assign SDO        = chain[0];
  assign Q          = q_r;
  assign PENDING    = pend;
  assign FRAME_DONE = frame_done_r;
  assign ERR        = err_r;

endmodule

// File: tb/tb_template_db_reg_bank.sv
// Bench for template_db_reg_bank: instance A (8x4, manual transfer) and instance B (8x3, auto transfer) share stimulus.
// Both are compared against a frame/shadow level reference model as well as directed expected values.
module tb_template_db_reg_bank;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        SHIFT_EN = 1'b0, SDI = 1'b0, LOAD_EN = 1'b0, TRANSFER = 1'b0, ERR_CLR = 1'b0;
  logic [1:0]  LOAD_ADDR = '0;
  logic [7:0]  LOAD_DATA = '0;
  logic [3:0]  CH_MASK = '0;

  logic [31:0] Q_A;
  logic [3:0]  PENDING_A;
  logic        SDO_A, FRAME_DONE_A, ERR_A;
  logic [23:0] Q_B;
  logic [2:0]  PENDING_B;
  logic        SDO_B, FRAME_DONE_B, ERR_B;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  template_db_reg_bank #(.WIDTH(8), .CHANNELS(4), .AUTO_XFER(0)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .SHIFT_EN(SHIFT_EN), .SDI(SDI), .SDO(SDO_A),
    .LOAD_EN(LOAD_EN), .LOAD_ADDR(LOAD_ADDR), .LOAD_DATA(LOAD_DATA),
    .TRANSFER(TRANSFER), .CH_MASK(CH_MASK), .ERR_CLR(ERR_CLR),
    .Q(Q_A), .PENDING(PENDING_A), .FRAME_DONE(FRAME_DONE_A), .ERR(ERR_A));

  template_db_reg_bank #(.WIDTH(8), .CHANNELS(3), .AUTO_XFER(1)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .SHIFT_EN(SHIFT_EN), .SDI(SDI), .SDO(SDO_B),
    .LOAD_EN(LOAD_EN), .LOAD_ADDR(LOAD_ADDR), .LOAD_DATA(LOAD_DATA),
    .TRANSFER(TRANSFER), .CH_MASK(CH_MASK[2:0]), .ERR_CLR(ERR_CLR),
    .Q(Q_B), .PENDING(PENDING_B), .FRAME_DONE(FRAME_DONE_B), .ERR(ERR_B));

  // reference model: index 0 = instance A, 1 = instance B
  int          M_CH   [2] = '{4, 3};
  bit          M_AUTO [2] = '{1'b0, 1'b1};
  logic [31:0] m_chain[2];
  logic [31:0] m_q    [2];
  logic [3:0]  m_pend [2];
  int          m_cnt  [2];
  logic        m_fd   [2];
  logic        m_ap   [2];
  logic        m_err  [2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_chain[m] = '0; m_q[m] = '0; m_pend[m] = '0; m_cnt[m] = 0;
      m_fd[m] = 1'b0; m_ap[m] = 1'b0; m_err[m] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      int          ch = M_CH[m];
      int          n = ch * 8;
      logic [31:0] nmask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
      logic [3:0]  all = 4'((1 << ch) - 1);
      logic [3:0]  cm = '0;
      logic        e = 1'b0;
      logic        nfd = 1'b0;
      if ((SHIFT_EN && LOAD_EN) || (SHIFT_EN && TRANSFER) || (LOAD_EN && TRANSFER)) e = 1'b1;
      if (M_AUTO[m] && m_ap[m]) begin
        if (SHIFT_EN || LOAD_EN) e = 1'b1;
        else cm = all;
      end
      if (SHIFT_EN) begin
        m_chain[m] = ((m_chain[m] >> 1) | (32'(SDI) << (n - 1))) & nmask;
        if (m_cnt[m] == n - 1) begin
          m_cnt[m] = 0; nfd = 1'b1; m_pend[m] = all;
        end else m_cnt[m]++;
      end else if (LOAD_EN) begin
        if (int'(LOAD_ADDR) < ch) begin
          m_chain[m][int'(LOAD_ADDR)*8 +: 8] = LOAD_DATA;
          m_pend[m][LOAD_ADDR] = 1'b1;
        end else e = 1'b1;
      end else if (TRANSFER) begin
        if (m_cnt[m] != 0) e = 1'b1;
        else cm = cm | (CH_MASK & all);
      end
      for (int c = 0; c < ch; c++) begin
        if (cm[c]) begin
          m_q[m][c*8 +: 8] = m_chain[m][c*8 +: 8];
          m_pend[m][c] = 1'b0;
        end
      end
      m_err[m] = e | (m_err[m] & ~ERR_CLR);
      m_ap[m]  = m_fd[m];
      m_fd[m]  = nfd;
    end
  endtask

  // one clock: model advances on the edge, outputs are sampled 1ns later, strobes drop
  task automatic tick();
    @(posedge CLK);
    if (RST_N) model_step();
    else model_reset();
    #1;
    SHIFT_EN = 1'b0; LOAD_EN = 1'b0; TRANSFER = 1'b0; ERR_CLR = 1'b0;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    tick(); tick();
    checks++; if (Q_A !== 32'h0) begin errors++; $display("FAIL reset_q_a got=%h exp=0", Q_A); end
    checks++; if (PENDING_A !== 4'h0) begin errors++; $display("FAIL reset_pend_a got=%h exp=0", PENDING_A); end
    checks++; if ({SDO_A, FRAME_DONE_A, ERR_A} !== 3'b000) begin errors++; $display("FAIL reset_flags_a got=%b exp=000", {SDO_A, FRAME_DONE_A, ERR_A}); end
    checks++; if ({Q_B, PENDING_B, SDO_B, FRAME_DONE_B, ERR_B} !== '0) begin errors++; $display("FAIL reset_b got=%h exp=0", {Q_B, PENDING_B, SDO_B, FRAME_DONE_B, ERR_B}); end
    RST_N = 1'b1;
  endtask

  task automatic test_serial();
    logic [31:0] v = 32'hA5C3_0F81;
    for (int i = 0; i < 32; i++) begin
      SHIFT_EN = 1'b1; SDI = v[i];
      tick();
      checks++; if (FRAME_DONE_A !== (i == 31)) begin errors++; $display("FAIL serial_frame_done shift=%0d got=%b exp=%b", i, FRAME_DONE_A, i == 31); end
    end
    checks++; if (PENDING_A !== 4'hF) begin errors++; $display("FAIL serial_pending got=%h exp=f", PENDING_A); end
    checks++; if (Q_A !== 32'h0) begin errors++; $display("FAIL serial_q_before_xfer got=%h exp=0", Q_A); end
    tick();
    checks++; if (FRAME_DONE_A !== 1'b0) begin errors++; $display("FAIL serial_fd_single got=%b exp=0", FRAME_DONE_A); end
    TRANSFER = 1'b1; CH_MASK = 4'hF;
    tick();
    checks++; if (Q_A !== v) begin errors++; $display("FAIL serial_q_after_xfer got=%h exp=%h", Q_A, v); end
    checks++; if (PENDING_A !== 4'h0) begin errors++; $display("FAIL serial_pend_after_xfer got=%h exp=0", PENDING_A); end
  endtask

  task automatic test_readback();
    logic [31:0] rb = '0;
    for (int i = 0; i < 32; i++) begin
      rb[i] = SDO_A;
      SHIFT_EN = 1'b1; SDI = 1'b0;
      tick();
    end
    checks++; if (rb !== 32'hA5C3_0F81) begin errors++; $display("FAIL readback_sdo got=%h exp=a5c30f81", rb); end
    checks++; if (Q_A !== 32'hA5C3_0F81) begin errors++; $display("FAIL readback_q_held got=%h exp=a5c30f81", Q_A); end
    checks++; if (SDO_A !== 1'b0) begin errors++; $display("FAIL readback_sdo_zero got=%b exp=0", SDO_A); end
  endtask

  task automatic test_masked_parallel();
    TRANSFER = 1'b1; CH_MASK = 4'hF;
    tick();
    checks++; if (Q_A !== 32'h0) begin errors++; $display("FAIL masked_clear_q got=%h exp=0", Q_A); end
    LOAD_EN = 1'b1; LOAD_ADDR = 2'd2; LOAD_DATA = 8'h3C;
    tick();
    checks++; if (PENDING_A !== 4'b0100) begin errors++; $display("FAIL masked_load_pend got=%b exp=0100", PENDING_A); end
    checks++; if (Q_A !== 32'h0) begin errors++; $display("FAIL masked_load_no_q got=%h exp=0", Q_A); end
    TRANSFER = 1'b1; CH_MASK = 4'b0100;
    tick();
    checks++; if (Q_A !== 32'h003C_0000) begin errors++; $display("FAIL masked_xfer_q got=%h exp=003c0000", Q_A); end
    checks++; if (PENDING_A !== 4'h0) begin errors++; $display("FAIL masked_xfer_pend got=%h exp=0", PENDING_A); end
    TRANSFER = 1'b1; CH_MASK = 4'h0;
    tick();
    checks++; if ({Q_A, ERR_A} !== {32'h003C_0000, 1'b0}) begin errors++; $display("FAIL mask_zero_noop got=%h/%b exp=003c0000/0", Q_A, ERR_A); end
  endtask

  task automatic test_collisions();
    LOAD_EN = 1'b1; LOAD_ADDR = 2'd1; LOAD_DATA = 8'h55; TRANSFER = 1'b1; CH_MASK = 4'hF;
    tick();
    checks++; if (ERR_A !== 1'b1) begin errors++; $display("FAIL coll_load_xfer_err got=%b exp=1", ERR_A); end
    checks++; if (Q_A !== 32'h003C_0000) begin errors++; $display("FAIL coll_load_xfer_q got=%h exp=003c0000", Q_A); end
    checks++; if (PENDING_A !== 4'b0010) begin errors++; $display("FAIL coll_load_xfer_pend got=%b exp=0010", PENDING_A); end
    ERR_CLR = 1'b1;
    tick();
    checks++; if (ERR_A !== 1'b0) begin errors++; $display("FAIL coll_err_clr got=%b exp=0", ERR_A); end
    TRANSFER = 1'b1; CH_MASK = 4'b0010;
    tick();
    checks++; if (Q_A !== 32'h003C_5500) begin errors++; $display("FAIL coll_shadow_written got=%h exp=003c5500", Q_A); end
    for (int i = 0; i < 3; i++) begin SHIFT_EN = 1'b1; SDI = 1'b1; tick(); end
    TRANSFER = 1'b1; CH_MASK = 4'hF; ERR_CLR = 1'b1;
    tick();
    checks++; if (Q_A !== 32'h003C_5500) begin errors++; $display("FAIL coll_midframe_q got=%h exp=003c5500", Q_A); end
    checks++; if (ERR_A !== 1'b1) begin errors++; $display("FAIL coll_midframe_err_set_wins got=%b exp=1", ERR_A); end
  endtask

  task automatic test_bad_addr();
    do_reset();
    LOAD_EN = 1'b1; LOAD_ADDR = 2'd1; LOAD_DATA = 8'h77;
    tick();
    LOAD_EN = 1'b1; LOAD_ADDR = 2'd3; LOAD_DATA = 8'hFF;
    tick();
    checks++; if (ERR_B !== 1'b1) begin errors++; $display("FAIL badaddr_err got=%b exp=1", ERR_B); end
    checks++; if (PENDING_B !== 3'b010) begin errors++; $display("FAIL badaddr_pend got=%b exp=010", PENDING_B); end
    TRANSFER = 1'b1; CH_MASK = 4'hF;
    tick();
    checks++; if (Q_B !== 24'h00_7700) begin errors++; $display("FAIL badaddr_shadow got=%h exp=007700", Q_B); end
    checks++; if (Q_A !== 32'hFF00_7700) begin errors++; $display("FAIL badaddr_valid_on_a got=%h exp=ff007700", Q_A); end
  endtask

  task automatic test_auto_xfer();
    logic [23:0] w1 = 24'($urandom) | 24'h1;
    logic [23:0] w2 = ~w1;
    do_reset();
    for (int i = 0; i < 24; i++) begin SHIFT_EN = 1'b1; SDI = w1[i]; tick(); end
    checks++; if ({FRAME_DONE_B, Q_B} !== {1'b1, 24'h0}) begin errors++; $display("FAIL auto_last_edge got=%b/%h exp=1/000000", FRAME_DONE_B, Q_B); end
    tick();
    checks++; if (Q_B !== 24'h0) begin errors++; $display("FAIL auto_one_cycle got=%h exp=000000", Q_B); end
    tick();
    checks++; if (Q_B !== w1) begin errors++; $display("FAIL auto_two_cycles got=%h exp=%h", Q_B, w1); end
    checks++; if ({PENDING_B, ERR_B} !== 4'b0000) begin errors++; $display("FAIL auto_pend_err got=%b exp=0000", {PENDING_B, ERR_B}); end
    for (int i = 0; i < 24; i++) begin SHIFT_EN = 1'b1; SDI = w2[i]; tick(); end
    tick();
    SHIFT_EN = 1'b1; SDI = 1'b0;
    tick();
    checks++; if (Q_B !== w1) begin errors++; $display("FAIL auto_dropped_q got=%h exp=%h", Q_B, w1); end
    checks++; if (ERR_B !== 1'b1) begin errors++; $display("FAIL auto_dropped_err got=%b exp=1", ERR_B); end
    checks++; if (Q_A !== 32'h0) begin errors++; $display("FAIL manual_no_auto got=%h exp=0", Q_A); end
  endtask

  task automatic test_mid_frame_reset();
    logic [31:0] r = $urandom | 32'h8000_0001;
    int          pulses = 0;
    int          at = -1;
    do_reset();
    for (int i = 0; i < 32; i++) begin SHIFT_EN = 1'b1; SDI = r[i]; tick(); end
    TRANSFER = 1'b1; CH_MASK = 4'hF;
    tick();
    checks++; if (Q_A !== r) begin errors++; $display("FAIL rst_setup_q got=%h exp=%h", Q_A, r); end
    for (int i = 0; i < 5; i++) begin SHIFT_EN = 1'b1; SDI = 1'b1; tick(); end
    LOAD_EN = 1'b1; TRANSFER = 1'b1; LOAD_ADDR = 2'd0; LOAD_DATA = 8'h11;
    tick();
    RST_N = 1'b0;
    #2;
    checks++; if ({Q_A, PENDING_A, ERR_A, SDO_A} !== '0) begin errors++; $display("FAIL rst_async got=%h/%h/%b/%b exp=0", Q_A, PENDING_A, ERR_A, SDO_A); end
    tick();
    RST_N = 1'b1;
    for (int i = 0; i < 40; i++) begin
      SHIFT_EN = (i < 32); SDI = 1'b1;
      tick();
      if (FRAME_DONE_A) begin pulses++; at = i; end
    end
    checks++; if (pulses != 1 || at != 31) begin errors++; $display("FAIL rst_next_frame pulses=%0d at=%0d exp=1 at 31", pulses, at); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      SHIFT_EN  = ($urandom_range(0, 99) < 35);
      SDI       = 1'($urandom);
      LOAD_EN   = ($urandom_range(0, 99) < 15);
      LOAD_ADDR = 2'($urandom);
      LOAD_DATA = 8'($urandom);
      TRANSFER  = ($urandom_range(0, 99) < 20);
      CH_MASK   = 4'($urandom);
      ERR_CLR   = ($urandom_range(0, 99) < 10);
      RST_N     = ($urandom_range(0, 99) >= 2);
      tick();
      RST_N = 1'b1;
      checks++; if (Q_A !== m_q[0]) begin errors++; $display("FAIL rand_q_a cyc=%0d got=%h exp=%h", i, Q_A, m_q[0]); end
      checks++; if ({PENDING_A, FRAME_DONE_A, ERR_A, SDO_A} !== {m_pend[0], m_fd[0], m_err[0], m_chain[0][0]})
        begin errors++; $display("FAIL rand_flags_a cyc=%0d got=%b exp=%b", i, {PENDING_A, FRAME_DONE_A, ERR_A, SDO_A}, {m_pend[0], m_fd[0], m_err[0], m_chain[0][0]}); end
      checks++; if (Q_B !== m_q[1][23:0]) begin errors++; $display("FAIL rand_q_b cyc=%0d got=%h exp=%h", i, Q_B, m_q[1][23:0]); end
      checks++; if ({PENDING_B, FRAME_DONE_B, ERR_B, SDO_B} !== {m_pend[1][2:0], m_fd[1], m_err[1], m_chain[1][0]})
        begin errors++; $display("FAIL rand_flags_b cyc=%0d got=%b exp=%b", i, {PENDING_B, FRAME_DONE_B, ERR_B, SDO_B}, {m_pend[1][2:0], m_fd[1], m_err[1], m_chain[1][0]}); end
    end
  endtask

  initial begin
    model_reset();
    #1;
    test_reset();
    test_serial();
    test_readback();
    test_masked_parallel();
    test_collisions();
    test_bad_addr();
    test_auto_xfer();
    test_mid_frame_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
